exec_group1: RTL and testbench
==============================

Name: exec_group1

Overview:
- Execute/writeback stage directly downstream of the 6502 fetch/address sequencer.
- Consumes the latched opcode class, operand byte and effective address that the sequencer presents in its load-register cycle.
- Executes the eight group-01 instructions: ORA, AND, EOR, ADC, STA, LDA, CMP, SBC. Owns the accumulator and status register and generates the STA memory write cycle.
- Binary arithmetic only; the D flag is stored but ignored.

Parameters:
RESET_A, 8'h00, accumulator value on reset
RESET_P, 8'h24, status value on reset (bit5=1, I=1)
ADDR_W, 16, effective address / memory address width

Ports:
CLK  in  1  rising-edge clock
R_N  in  1  asynchronous active-low reset
OP_VALID  in  1  operand/EA valid strobe from sequencer
OPCODE  in  3  op[7:5] instruction class (aaa field)
OPERAND  in  8  memory or immediate operand byte
EA  in  ADDR_W  effective address for STA
FLAG_WR  in  1  load status register from FLAG_IN
FLAG_IN  in  8  new status value
OP_READY  out  1  high when unit accepts OP_VALID
A  out  8  accumulator
P  out  8  status NV1BDIZC
MEM_WE  out  1  memory write enable (STA)
MEM_ADDR  out  ADDR_W  write address
MEM_DATA  out  8  write data
DONE  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, EXEC, WRITE. OP_READY = (state==IDLE), combinational.
- IDLE, OP_VALID=1 at an edge: latch OPCODE/OPERAND/EA, go to EXEC. OP_VALID in EXEC/WRITE is ignored; nothing is queued.
- EXEC, next edge:
  - OPCODE!=100: update A/P per rules below, go to IDLE, DONE<=1.
  - OPCODE==100: go to WRITE; A/P unchanged.
- WRITE: MEM_WE=1, MEM_ADDR=latched EA, MEM_DATA=A (combinational from state). Next edge: go to IDLE, DONE<=1.
- DONE is registered: high exactly the one cycle after the completing edge, else 0.
- Latency: OP_VALID edge k -> A/P valid after edge k+1. STA writes during cycle k+1..k+2, DONE high k+2..k+3.
- Arithmetic rules (M=latched operand, Cin=P[0]); 9-bit sums, bit8 is carry:
  - ORA/AND/EOR: A<=A op M; N,Z.
  - LDA: A<=M; N,Z.
  - ADC: S=A+M+Cin; A<=S[7:0]; C=S[8]; V=(A[7]==M[7])&&(S[7]!=A[7]); N,Z.
  - SBC: same as ADC with M replaced by ~M.
  - CMP: S=A+~M+1; A unchanged; C=S[8], N=S[7], Z=(S[7:0]==0); V unchanged.
  - STA: no flag change.
  - N=result[7], Z=(result==0). Bits 5,4,3,2 are never altered by execution.
- FLAG_WR:
  - Honoured only in IDLE with OP_VALID=0: P<=FLAG_IN with bit5 forced 1.
  - FLAG_WR and OP_VALID together in IDLE: OP_VALID wins, FLAG_WR dropped.
  - FLAG_WR outside IDLE is ignored.
- Reset (R_N=0, async, any state): state=IDLE, A=RESET_A, P=RESET_P, DONE=0, MEM_WE=0 immediately. An STA in progress is aborted with no partial write. Latched operand/EA registers need no reset.
- Wrap-around: 8-bit results wrap modulo 256; carry only via C.

Test Plan:
- Reset: R_N low mid-cycle -> A=00, P=24, OP_READY=1, MEM_WE=0, DONE=0 without a clock edge.
- ADC overflow: FLAG_WR 24 (C=0); LDA 50; ADC 50 -> A=A0, P=E4 (N=1,V=1,Z=0,C=0); DONE one cycle after each op.
- SBC borrow: FLAG_WR 25 (C=1); LDA 00; SBC 01 -> A=FF, N=1, C=0, V=0, Z=0.
- CMP equal: LDA 40; CMP 40 -> A=40, Z=1, C=1, N=0, V unchanged.
- STA: LDA A5; STA with EA=1234 -> MEM_WE high exactly one cycle with MEM_ADDR=1234, MEM_DATA=A5; DONE the following cycle; P unchanged.
- Collisions: OP_VALID held high through EXEC -> only one op executes. FLAG_WR with OP_VALID in IDLE -> P from the op only. R_N asserted during WRITE -> MEM_WE drops immediately, no DONE.

Source files
------------

// File: rtl/exec_group1_if.sv
// exec_group1_if
//   Bundle between the fetch/address sequencer (master) and the
//   group-01 execute/writeback stage (slave).
//   Sequencer -> exec : OP_VALID, OPCODE, OPERAND, EA, FLAG_WR, FLAG_IN
//   Exec -> sequencer : OP_READY, A, P, MEM_WE, MEM_ADDR, MEM_DATA, DONE
interface exec_group1_if #(
    parameter int ADDR_W = 16
);
    logic              OP_VALID;
    logic [2:0]        OPCODE;
    logic [7:0]        OPERAND;
    logic [ADDR_W-1:0] EA;
    logic              FLAG_WR;
    logic [7:0]        FLAG_IN;
    logic              OP_READY;
    logic [7:0]        A;
    logic [7:0]        P;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [7:0]        MEM_DATA;
    logic              DONE;

    modport master (
        output OP_VALID, OPCODE, OPERAND, EA, FLAG_WR, FLAG_IN,
        input  OP_READY, A, P, MEM_WE, MEM_ADDR, MEM_DATA, DONE
    );

    modport slave (
        input  OP_VALID, OPCODE, OPERAND, EA, FLAG_WR, FLAG_IN,
        output OP_READY, A, P, MEM_WE, MEM_ADDR, MEM_DATA, DONE
    );
endinterface

// File: rtl/exec_group1.sv
// exec_group1
//   6502 group-01 execute/writeback stage (ORA AND EOR ADC STA LDA CMP SBC).
//   Owns the accumulator and status register and produces the STA write
//   cycle. Binary arithmetic only; D is stored but has no effect.
// Ports:
//   CLK  - rising-edge clock
//   R_N  - asynchronous active-low reset
//   bus  - exec_group1_if.slave: operand strobe/handshake from the
//          sequencer, status load, A/P view, memory write bus, DONE pulse
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready; accepts an operand, or a status load when none offered
// EXEC  | latched op executes on the next edge (STA moves on to WRITE)
// WRITE | MEM_WE asserted with latched EA and current A
module exec_group1 #(
    parameter logic [7:0] RESET_A = 8'h00,
    parameter logic [7:0] RESET_P = 8'h24,
    parameter int         ADDR_W  = 16
) (
    input  logic          CLK,
    input  logic          R_N,
    exec_group1_if.slave  bus
);
    localparam logic [2:0] OP_ORA = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_EOR = 3'b010;
    localparam logic [2:0] OP_ADC = 3'b011;
    localparam logic [2:0] OP_STA = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_SBC = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        a_q;
    logic [7:0]        p_q;
    logic              done_q;
    logic [2:0]        op_q;
    logic [7:0]        m_q;
    logic [ADDR_W-1:0] ea_q;

    logic [7:0]        m_eff;
    logic              c_in;
    logic [8:0]        sum;
    logic              v_add;
    logic [7:0]        nz_val;
    logic [7:0]        res_a;
    logic [7:0]        res_p;

    // One adder serves ADC, SBC and CMP: SBC/CMP add the inverted operand,
    // CMP forces the carry-in so it never depends on the current C.
    always_comb begin
        m_eff  = (op_q == OP_SBC || op_q == OP_CMP) ? ~m_q : m_q;
        c_in   = (op_q == OP_CMP) ? 1'b1 : p_q[0];
        sum    = {1'b0, a_q} + {1'b0, m_eff} + {8'b0, c_in};
        v_add  = (a_q[7] == m_eff[7]) && (sum[7] != a_q[7]);
        res_a  = a_q;
        res_p  = p_q;
        case (op_q)
            OP_ORA: res_a = a_q | m_q;
            OP_AND: res_a = a_q & m_q;
            OP_EOR: res_a = a_q ^ m_q;
            OP_ADC,
            OP_SBC: begin
                res_a    = sum[7:0];
                res_p[0] = sum[8];
                res_p[6] = v_add;
            end
            OP_LDA: res_a = m_q;
            OP_CMP: res_p[0] = sum[8];
            default: ;
        endcase
        // CMP derives N/Z from the difference, not from A
        nz_val = (op_q == OP_CMP) ? sum[7:0] : res_a;
        if (op_q != OP_STA) begin
            res_p[7] = nz_val[7];
            res_p[1] = (nz_val == 8'h00);
        end
    end

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            state  <= IDLE;
            a_q    <= RESET_A;
            p_q    <= RESET_P;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.OP_VALID) begin
                        state <= EXEC;
                    end else if (bus.FLAG_WR) begin
                        p_q <= bus.FLAG_IN | 8'h20;
                    end
                end
                EXEC: begin
                    if (op_q == OP_STA) begin
                        state <= WRITE;
                    end else begin
                        a_q    <= res_a;
                        p_q    <= res_p;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                WRITE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/EA capture needs no reset; it is only read after a capture.
    always_ff @(posedge CLK) begin
        if (state == IDLE && bus.OP_VALID) begin
            op_q <= bus.OPCODE;
            m_q  <= bus.OPERAND;
            ea_q <= bus.EA;
        end
    end

    assign bus.OP_READY = (state == IDLE);
    assign bus.MEM_WE   = (state == WRITE);
    assign bus.MEM_ADDR = ea_q;
    assign bus.MEM_DATA = a_q;
    assign bus.A        = a_q;
    assign bus.P        = p_q;
    assign bus.DONE     = done_q;
endmodule

// File: tb/tb_exec_group1.sv
module tb_exec_group1;
    localparam logic [2:0] ORA = 3'b000, AND = 3'b001, EOR = 3'b010, ADC = 3'b011;
    localparam logic [2:0] STA = 3'b100, LDA = 3'b101, CMP = 3'b110, SBC = 3'b111;

    logic CLK = 1'b0;
    logic R_N = 1'b0;
    always #5 CLK = ~CLK;

    exec_group1_if #(.ADDR_W(16)) bus();

    exec_group1 #(.RESET_A(8'h00), .RESET_P(8'h24), .ADDR_W(16)) dut (
        .CLK (CLK),
        .R_N (R_N),
        .bus (bus)
    );

    typedef struct {
        logic       fw;
        logic [7:0] fin;
        logic [2:0] opc;
        logic [7:0] m;
        logic [7:0] ea;
        logic [7:0] ep;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] p;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[14];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic flag_write(input logic [7:0] v);
        @(negedge CLK);
        bus.FLAG_WR = 1'b1;
        bus.FLAG_IN = v;
        @(negedge CLK);
        bus.FLAG_WR = 1'b0;
        chk("flag_wr_p", 32'(bus.P), 32'(v | 8'h20));
    endtask

    task automatic run_op(input string name, input logic [2:0] opc, input logic [7:0] m,
                          input logic [7:0] ea, input logic [7:0] ep, input int lat);
        exp_t e;
        int   c;
        bit   seen;
        @(negedge CLK);
        chk({name, "_ready"}, 32'(bus.OP_READY), 32'd1);
        chk({name, "_done_idle"}, 32'(bus.DONE), 32'd0);
        bus.OP_VALID = 1'b1;
        bus.OPCODE   = opc;
        bus.OPERAND  = m;
        e.a = ea; e.p = ep; e.lat = lat;
        sb.push_back(e);
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        c = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            c++;
            if (bus.DONE === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_latency"}, 32'(c), 32'(e.lat));
            chk({name, "_a"}, 32'(bus.A), 32'(e.a));
            chk({name, "_p"}, 32'(bus.P), 32'(e.p));
        end
    endtask

    initial begin
        int dcount;
        bus.OP_VALID = 1'b0;
        bus.OPCODE   = 3'b000;
        bus.OPERAND  = 8'h00;
        bus.EA       = 16'h0000;
        bus.FLAG_WR  = 1'b0;
        bus.FLAG_IN  = 8'h00;

        tbl[0]  = '{1'b1, 8'h24, LDA, 8'h50, 8'h50, 8'h24};
        tbl[1]  = '{1'b0, 8'h00, ADC, 8'h50, 8'hA0, 8'hE4};
        tbl[2]  = '{1'b1, 8'h25, LDA, 8'h00, 8'h00, 8'h27};
        tbl[3]  = '{1'b0, 8'h00, SBC, 8'h01, 8'hFF, 8'hA4};
        tbl[4]  = '{1'b0, 8'h00, LDA, 8'h40, 8'h40, 8'h24};
        tbl[5]  = '{1'b0, 8'h00, CMP, 8'h40, 8'h40, 8'h27};
        tbl[6]  = '{1'b0, 8'h00, ORA, 8'h0F, 8'h4F, 8'h25};
        tbl[7]  = '{1'b0, 8'h00, AND, 8'hF0, 8'h40, 8'h25};
        tbl[8]  = '{1'b0, 8'h00, EOR, 8'h40, 8'h00, 8'h27};
        tbl[9]  = '{1'b0, 8'h00, ADC, 8'hFF, 8'h00, 8'h27};
        tbl[10] = '{1'b0, 8'h00, CMP, 8'h01, 8'h00, 8'hA4};
        tbl[11] = '{1'b1, 8'hC0, LDA, 8'h7F, 8'h7F, 8'h60};
        tbl[12] = '{1'b0, 8'h00, SBC, 8'h80, 8'hFE, 8'hE0};
        tbl[13] = '{1'b1, 8'h01, ADC, 8'h01, 8'h00, 8'h23};

        #12 R_N = 1'b1;
        chk("reset_a", 32'(bus.A), 32'h00);
        chk("reset_p", 32'(bus.P), 32'h24);

        // Asynchronous reset between edges while DONE is high
        flag_write(8'hFF);
        @(negedge CLK);
        bus.OP_VALID = 1'b1;
        bus.OPCODE   = LDA;
        bus.OPERAND  = 8'h55;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        @(negedge CLK);
        chk("pre_rst_a", 32'(bus.A), 32'h55);
        chk("pre_rst_done", 32'(bus.DONE), 32'd1);
        #2 R_N = 1'b0;
        #1;
        chk("async_rst_a", 32'(bus.A), 32'h00);
        chk("async_rst_p", 32'(bus.P), 32'h24);
        chk("async_rst_ready", 32'(bus.OP_READY), 32'd1);
        chk("async_rst_we", 32'(bus.MEM_WE), 32'd0);
        chk("async_rst_done", 32'(bus.DONE), 32'd0);
        @(negedge CLK);
        R_N = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].fw) flag_write(tbl[i].fin);
            run_op($sformatf("vec%0d", i), tbl[i].opc, tbl[i].m, tbl[i].ea, tbl[i].ep, 1);
        end

        // STA: one-cycle write, DONE the cycle after
        run_op("lda_a5", LDA, 8'hA5, 8'hA5, 8'hA1, 1);
        @(negedge CLK);
        bus.OP_VALID = 1'b1;
        bus.OPCODE   = STA;
        bus.OPERAND  = 8'h00;
        bus.EA       = 16'h1234;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        bus.EA       = 16'h0000;
        chk("sta_exec_we", 32'(bus.MEM_WE), 32'd0);
        @(negedge CLK);
        chk("sta_we", 32'(bus.MEM_WE), 32'd1);
        chk("sta_addr", 32'(bus.MEM_ADDR), 32'h1234);
        chk("sta_data", 32'(bus.MEM_DATA), 32'hA5);
        chk("sta_write_done", 32'(bus.DONE), 32'd0);
        @(negedge CLK);
        chk("sta_we_off", 32'(bus.MEM_WE), 32'd0);
        chk("sta_done", 32'(bus.DONE), 32'd1);
        chk("sta_p", 32'(bus.P), 32'hA1);
        chk("sta_a", 32'(bus.A), 32'hA5);
        @(negedge CLK);
        chk("sta_done_pulse", 32'(bus.DONE), 32'd0);

        // OP_VALID held through EXEC, FLAG_WR during EXEC: one op, no status load
        @(negedge CLK);
        bus.OP_VALID = 1'b1;
        bus.OPCODE   = LDA;
        bus.OPERAND  = 8'h11;
        @(negedge CLK);
        bus.OPERAND  = 8'h22;
        bus.FLAG_WR  = 1'b1;
        bus.FLAG_IN  = 8'hFF;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        bus.FLAG_WR  = 1'b0;
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.DONE === 1'b1) dcount++;
            @(negedge CLK);
        end
        chk("hold_done_count", 32'(dcount), 32'd1);
        chk("hold_a", 32'(bus.A), 32'h11);
        chk("hold_p", 32'(bus.P), 32'h21);

        // FLAG_WR together with OP_VALID in IDLE: the op wins
        @(negedge CLK);
        bus.OP_VALID = 1'b1;
        bus.OPCODE   = LDA;
        bus.OPERAND  = 8'h00;
        bus.FLAG_WR  = 1'b1;
        bus.FLAG_IN  = 8'hC3;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        bus.FLAG_WR  = 1'b0;
        @(negedge CLK);
        chk("coll_done", 32'(bus.DONE), 32'd1);
        chk("coll_a", 32'(bus.A), 32'h00);
        chk("coll_p", 32'(bus.P), 32'h23);

        // Reset during WRITE aborts the store, no DONE
        @(negedge CLK);
        bus.OP_VALID = 1'b1;
        bus.OPCODE   = STA;
        bus.EA       = 16'hBEEF;
        @(negedge CLK);
        bus.OP_VALID = 1'b0;
        @(negedge CLK);
        chk("abort_we_before", 32'(bus.MEM_WE), 32'd1);
        #2 R_N = 1'b0;
        #1;
        chk("abort_we", 32'(bus.MEM_WE), 32'd0);
        chk("abort_ready", 32'(bus.OP_READY), 32'd1);
        chk("abort_p", 32'(bus.P), 32'h24);
        @(negedge CLK);
        R_N = 1'b1;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1 || bus.MEM_WE === 1'b1) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
